// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder.
// Access sizes and responder FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed bytes from an aligned
// dword and sign- or zero-extends them to 64 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [63:0] rdata
);

  logic [63:0] shifted;

  always_comb begin
    shifted = dword >> {offset, 3'b000};
    rdata   = '0;
    unique case (size)
      SZ_BYTE:
        rdata = is_unsigned ? {56'd0, shifted[7:0]}
                            : {{56{shifted[7]}}, shifted[7:0]};
      SZ_HALF:
        rdata = is_unsigned ? {48'd0, shifted[15:0]}
                            : {{48{shifted[15]}}, shifted[15:0]};
      SZ_WORD:
        rdata = is_unsigned ? {32'd0, shifted[31:0]}
                            : {{32{shifted[31]}}, shifted[31:0]};
      SZ_DWORD:
        rdata = shifted;
      default:
        rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with fixed-latency valid/ready
// request/response handshake, little-endian, alignment-checked.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, uns_q;
  logic [63:0] addr_q, wdata_q;
  size_e       size_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept, fire, retire, acc_err;
  logic [3:0]  nbytes;
  logic [64:0] span;
  logic [AW-1:0] base;
  logic [63:0] window, load_data;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign fire   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign retire = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      state_q == ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      state_q == ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Range check is done in 65 bits so addresses near 2^64 cannot wrap.
  always_comb begin
    nbytes  = size_bytes(size_q);
    span    = {1'b0, addr_q} + {61'd0, nbytes};
    acc_err = ((addr_q[3:0] & (nbytes - 4'd1)) != 4'd0)
           || (span > 65'(DEPTH_BYTES));
  end

  always_comb begin
    base   = addr_q[AW-1:0] & ~AW'(7);
    window = '0;
    for (int k = 0; k < 8; k++) begin
      if (int'(base) + k < DEPTH_BYTES)
        window[k*8 +: 8] = mem[AW'(int'(base) + k)];
    end
  end

  mem_load_align u_align (
    .dword       (window),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= size_e'(req_size);
      end
      if (fire) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || write_q) ? 64'd0 : load_data;
      end else if (retire) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
    end else if (fire && write_q && !acc_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes)
          mem[AW'(int'(addr_q[AW-1:0]) + k)] <= wdata_q[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus
// stall, no-accept-on-retire and mid-access reset sequences.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        w;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.DEPTH_BYTES(64), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [63:0] a,
                       input logic [1:0] s, input logic u,
                       input logic [63:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_size = s; req_unsigned = u; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for rsp_valid after the accepting edge; returns cycles taken.
  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(posedge clk);
      #1 lat++;
    end
    if (!rsp_valid) begin
      chk({name, " timeout"}, 64'(rsp_valid), 64'd1);
    end
  endtask

  task automatic retire_rsp;
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input string name, input vec_t v);
    int lat;
    issue(v.w, v.addr, v.size, v.uns, v.wdata);
    wait_rsp(name, lat);
    chk({name, " latency"}, 64'(lat), 64'd2);
    chk({name, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, " err"}, 64'(rsp_err), 64'(v.exp_err));
    retire_rsp();
    chk({name, " post rdata"}, rsp_rdata, 64'd0);
    chk({name, " post valid"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic add(input logic w, input logic [63:0] a,
                     input logic [1:0] s, input logic u,
                     input logic [63:0] d, input logic [63:0] er,
                     input logic ee);
    vec_t v;
    v.w = w; v.addr = a; v.size = s; v.uns = u;
    v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] held;
    int lat;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_size = '0; req_unsigned = 1'b0;
    req_wdata = '0; rsp_ready = 1'b0;

    add(1, 64'd8,  2'd3, 0, 64'h1122334455667788, 64'h0, 0);
    add(0, 64'd15, 2'd0, 0, 64'h0, 64'h11, 0);
    add(0, 64'd8,  2'd3, 0, 64'h0, 64'h1122334455667788, 0);
    add(0, 64'd8,  2'd0, 1, 64'h0, 64'h88, 0);
    add(0, 64'd8,  2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF88, 0);
    add(0, 64'd12, 2'd2, 0, 64'h0, 64'h11223344, 0);
    add(1, 64'd8,  2'd1, 0, 64'hDEAD000000008000, 64'h0, 0);
    add(0, 64'd8,  2'd1, 0, 64'h0, 64'hFFFFFFFFFFFF8000, 0);
    add(0, 64'd8,  2'd1, 1, 64'h0, 64'h8000, 0);
    add(0, 64'd8,  2'd3, 1, 64'h0, 64'h1122334455668000, 0);
    add(0, 64'd8,  2'd2, 0, 64'h0, 64'h55668000, 0);
    add(0, 64'd6,  2'd2, 0, 64'h0, 64'h0, 1);
    add(1, 64'd56, 2'd3, 0, 64'h0102030405060708, 64'h0, 0);
    add(1, 64'd64, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1);
    add(0, 64'd56, 2'd3, 0, 64'h0, 64'h0102030405060708, 0);
    add(0, 64'd60, 2'd2, 0, 64'h0, 64'h01020304, 0);
    add(1, 64'd60, 2'd2, 0, 64'hFFFFFFFF80000001, 64'h0, 0);
    add(0, 64'd60, 2'd2, 0, 64'h0, 64'hFFFFFFFF80000001, 0);
    add(0, 64'd60, 2'd2, 1, 64'h0, 64'h80000001, 0);
    add(0, 64'd63, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
    add(0, 64'd56, 2'd3, 1, 64'h0, 64'h8000000105060708, 0);
    add(0, 64'd63, 2'd1, 0, 64'h0, 64'h0, 1);
    add(0, 64'd64, 2'd0, 0, 64'h0, 64'h0, 1);
    add(0, 64'hFFFFFFFFFFFFFFF8, 2'd3, 0, 64'h0, 64'h0, 1);
    add(1, 64'd3,  2'd0, 0, 64'h12345678000000AB, 64'h0, 0);
    add(0, 64'd0,  2'd2, 0, 64'h0, 64'hFFFFFFFFAB000000, 0);
    add(0, 64'd0,  2'd2, 1, 64'h0, 64'hAB000000, 0);

    #12;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) xact($sformatf("vec%0d", i), vecs[i]);

    // Stall in RESP while req_valid toggles with a store to addr 0.
    issue(0, 64'd8, 2'd3, 0, 64'h0);
    wait_rsp("stall", lat);
    held = rsp_rdata;
    chk("stall first rdata", held, 64'h1122334455668000);
    req_write = 1'b1; req_addr = 64'd0; req_size = 2'd0;
    req_wdata = 64'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = ~req_valid;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d valid", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d rdata", c), rsp_rdata, held);
      chk($sformatf("stall%0d ready", c), 64'(req_ready), 64'd0);
    end
    @(negedge clk) begin rsp_ready = 1'b1; req_valid = 1'b1; end
    @(posedge clk);
    #1 begin rsp_ready = 1'b0; req_valid = 1'b0; end
    chk("retire no accept", 64'(req_ready), 64'd1);
    begin
      vec_t v;
      v.w = 0; v.addr = 64'd0; v.size = 2'd0; v.uns = 1;
      v.wdata = '0; v.exp_rdata = 64'h0; v.exp_err = 0;
      xact("no store during resp", v);
    end

    // Reset while a store of 0xFF to addr 0 is in BUSY.
    issue(1, 64'd0, 2'd0, 0, 64'hFF);
    chk("midbusy ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_rdata", rsp_rdata, 64'd0);
    chk("rst rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    begin
      vec_t v;
      v.w = 0; v.addr = 64'd0; v.size = 2'd0; v.uns = 1;
      v.wdata = '0; v.exp_rdata = 64'h0; v.exp_err = 0;
      xact("after rst byte0", v);
      v.addr = 64'd8; v.size = 2'd3;
      xact("after rst dword8", v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 64, byte capacity of the memory array.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  processor presents a memory request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  64  store data; low 8/16/32/64 bits used per req_size.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  processor accepts the response.
REQ-014 SHALL have port rsp_rdata  output  64  load result, extended to 64 bits.
REQ-015 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-018 SHALL accept a request when req_valid && req_ready: latch all req_* fields, load counter with LATENCY-1, go to BUSY.
REQ-019 SHALL decrement the counter each BUSY cycle; at counter 0 perform the access and go to RESP, so rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 SHALL store little-endian: byte k of the access goes to address addr+k.
REQ-021 SHALL flag error when addr is not a multiple of 2^size, or addr + 2^size > DEPTH_BYTES (64-bit compare, no wrap).
REQ-022 On error SHALL leave memory unchanged, set rsp_err = 1 and rsp_rdata = 0.
REQ-023 On a store SHALL write only the 2^size addressed bytes and return rsp_rdata = 0, rsp_err = 0.
REQ-024 On a load SHALL return the addressed bytes, sign- or zero-extended per req_unsigned (dword ignores req_unsigned).
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1.
REQ-026 On rsp_valid && rsp_ready SHALL return to IDLE and clear rsp_rdata/rsp_err to 0; no request is accepted in that same cycle.
REQ-027 SHALL ignore req_* inputs in BUSY and RESP.

Reset
REQ-028 While reset = 0 SHALL force state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 SHALL clear every memory byte to 0 on reset; a reset during BUSY or RESP discards the pending access (no partial store).

Structure
REQ-030 SHALL place the size encodings and the FSM state encoding in shared package mem_pkg.
REQ-031 SHALL use one combinational sub-module mem_load_align for byte selection and sign/zero extension of load data.

Verification
REQ-032 Reset, store dword 0x1122334455667788 at addr 8, LATENCY=2 -> rsp_valid rises 2 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-033 Then load byte addr 15 signed -> rsp_rdata=0x0000000000000011; load half addr 8 signed after storing 0x8000 there -> 0xFFFFFFFFFFFF8000; same unsigned -> 0x0000000000008000.
REQ-034 Load word addr 6 -> rsp_err=1, rsp_rdata=0; store dword addr 64 (DEPTH_BYTES=64) -> rsp_err=1 and subsequent dword load at addr 56 returns prior contents.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid -> rsp outputs stable, req_ready=0, no second request accepted.
REQ-036 Assert reset=0 mid-BUSY of a store of 0xFF to addr 0 -> outputs at reset values immediately, subsequent byte load at addr 0 returns 0.
